// File: rtl/v_rams_dp_pipe.sv
// ---------------------------------------------------------------------------
// v_rams_dp_pipe
//   Simple dual-port RAM (one read/write port A, one read-only port B) on a
//   single clock, with registered addresses, optional extra output register
//   and valid flags travelling alongside the read data.
//
// Parameters
//   DATA_W  : word width in bits (1..64)
//   ADDR_W  : address width, depth = 2**ADDR_W
//   WR_MODE : port A read-during-write, 0 write-first, 1 read-first,
//             2 no-change
//   OUT_REG : 1 adds an output register stage on both ports
//
// Ports
//   clk        : clock, all state updates on rising edge
//   rst        : asynchronous active-high reset (pipeline only, not the RAM)
//   ena, we    : port A enable / write enable (we qualified by ena)
//   a, di      : port A address / write data
//   enb, dpra  : port B read enable / read address
//   spo        : port A read data,  spo_valid : spo holds fresh data
//   dpo        : port B read data,  dpo_valid : dpo holds fresh data
// ---------------------------------------------------------------------------
module v_rams_dp_pipe #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 7,
  parameter int WR_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] di,
  input  logic              enb,
  input  logic [ADDR_W-1:0] dpra,
  output logic [DATA_W-1:0] spo,
  output logic              spo_valid,
  output logic [DATA_W-1:0] dpo,
  output logic              dpo_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] ram [DEPTH];

  // The RAM sits in an async-reset process with an empty reset branch so that
  // writes are suppressed for as long as rst is high while contents survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (ena && we) begin
      ram[a] <= di;
    end
  end

  // -------------------------------------------------------------------------
  // Port A stage 1
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] a_addr_d, a_addr_q;
  logic              a_vld1_d, a_vld1_q;
  logic              a_pre_sel_d, a_pre_sel_q;
  logic [DATA_W-1:0] a_pre_d, a_pre_q;
  logic [DATA_W-1:0] a_hold_d, a_hold_q;
  logic [DATA_W-1:0] a_rd1;

  always_comb begin
    a_addr_d    = a_addr_q;
    a_vld1_d    = 1'b0;
    a_pre_sel_d = a_pre_sel_q;
    a_pre_d     = a_pre_q;
    if (ena) begin
      a_addr_d    = a;
      // no-change mode suppresses the read of a writing access entirely
      a_vld1_d    = !(we && (WR_MODE == 2));
      // read-first needs the word as it was before this edge's write
      a_pre_sel_d = we && (WR_MODE == 1);
      if (we && (WR_MODE == 1)) begin
        a_pre_d = ram[a];
      end
    end
  end

  // Reading the array through the registered address naturally yields the
  // freshly written word, which gives write-first behaviour for free.
  always_comb begin
    if (a_vld1_q) begin
      a_rd1 = a_pre_sel_q ? a_pre_q : ram[a_addr_q];
    end else begin
      a_rd1 = a_hold_q;
    end
    a_hold_d = a_rd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_addr_q    <= '0;
      a_vld1_q    <= 1'b0;
      a_pre_sel_q <= 1'b0;
      a_pre_q     <= '0;
      a_hold_q    <= '0;
    end else begin
      a_addr_q    <= a_addr_d;
      a_vld1_q    <= a_vld1_d;
      a_pre_sel_q <= a_pre_sel_d;
      a_pre_q     <= a_pre_d;
      a_hold_q    <= a_hold_d;
    end
  end

  // -------------------------------------------------------------------------
  // Port B stage 1
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] b_addr_d, b_addr_q;
  logic              b_vld1_d, b_vld1_q;
  logic [DATA_W-1:0] b_hold_d, b_hold_q;
  logic [DATA_W-1:0] b_rd1;

  always_comb begin
    b_addr_d = b_addr_q;
    b_vld1_d = 1'b0;
    if (enb) begin
      b_addr_d = dpra;
      b_vld1_d = 1'b1;
    end
  end

  // A same-cycle write to the same word is already in the array when the
  // registered address is looked up, so port B always sees the new data.
  always_comb begin
    b_rd1    = b_vld1_q ? ram[b_addr_q] : b_hold_q;
    b_hold_d = b_rd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_addr_q <= '0;
      b_vld1_q <= 1'b0;
      b_hold_q <= '0;
    end else begin
      b_addr_q <= b_addr_d;
      b_vld1_q <= b_vld1_d;
      b_hold_q <= b_hold_d;
    end
  end

  // -------------------------------------------------------------------------
  // Optional output register stage; loads only behind valid stage-1 data
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] spo_d, spo_q;
  logic              spo_vld_d, spo_vld_q;
  logic [DATA_W-1:0] dpo_d, dpo_q;
  logic              dpo_vld_d, dpo_vld_q;

  always_comb begin
    spo_d     = a_vld1_q ? a_rd1 : spo_q;
    spo_vld_d = a_vld1_q;
    dpo_d     = b_vld1_q ? b_rd1 : dpo_q;
    dpo_vld_d = b_vld1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spo_q     <= '0;
      spo_vld_q <= 1'b0;
      dpo_q     <= '0;
      dpo_vld_q <= 1'b0;
    end else begin
      spo_q     <= spo_d;
      spo_vld_q <= spo_vld_d;
      dpo_q     <= dpo_d;
      dpo_vld_q <= dpo_vld_d;
    end
  end

  assign spo       = (OUT_REG != 0) ? spo_q     : a_rd1;
  assign spo_valid = (OUT_REG != 0) ? spo_vld_q : a_vld1_q;
  assign dpo       = (OUT_REG != 0) ? dpo_q     : b_rd1;
  assign dpo_valid = (OUT_REG != 0) ? dpo_vld_q : b_vld1_q;

endmodule

// File: tb/tb_v_rams_dp_pipe.sv
// Scoreboard bench for v_rams_dp_pipe. Four instances share the stimulus:
//   inst0 WR_MODE=0 OUT_REG=0, inst1 WR_MODE=1 OUT_REG=0,
//   inst2 WR_MODE=2 OUT_REG=0, inst3 WR_MODE=0 OUT_REG=1.
// Channel ch = 2*inst + port (port 0 = spo, port 1 = dpo).
module tb_v_rams_dp_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        we = 1'b0;
  logic [6:0]  a = '0;
  logic [15:0] di = '0;
  logic        enb = 1'b0;
  logic [6:0]  dpra = '0;

  logic [15:0] spo0, dpo0, spo1, dpo1, spo2, dpo2, spo3, dpo3;
  logic        sv0, dv0, sv1, dv1, sv2, dv2, sv3, dv3;

  always #5 clk = ~clk;

  v_rams_dp_pipe #(.DATA_W(16), .ADDR_W(7), .WR_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .we(we), .a(a), .di(di), .enb(enb), .dpra(dpra),
    .spo(spo0), .spo_valid(sv0), .dpo(dpo0), .dpo_valid(dv0));
  v_rams_dp_pipe #(.DATA_W(16), .ADDR_W(7), .WR_MODE(1), .OUT_REG(0)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .we(we), .a(a), .di(di), .enb(enb), .dpra(dpra),
    .spo(spo1), .spo_valid(sv1), .dpo(dpo1), .dpo_valid(dv1));
  v_rams_dp_pipe #(.DATA_W(16), .ADDR_W(7), .WR_MODE(2), .OUT_REG(0)) u2 (
    .clk(clk), .rst(rst), .ena(ena), .we(we), .a(a), .di(di), .enb(enb), .dpra(dpra),
    .spo(spo2), .spo_valid(sv2), .dpo(dpo2), .dpo_valid(dv2));
  v_rams_dp_pipe #(.DATA_W(16), .ADDR_W(7), .WR_MODE(0), .OUT_REG(1)) u3 (
    .clk(clk), .rst(rst), .ena(ena), .we(we), .a(a), .di(di), .enb(enb), .dpra(dpra),
    .spo(spo3), .spo_valid(sv3), .dpo(dpo3), .dpo_valid(dv3));

  logic [15:0] o_data [8];
  logic        o_vld  [8];
  assign o_data[0] = spo0; assign o_vld[0] = sv0;
  assign o_data[1] = dpo0; assign o_vld[1] = dv0;
  assign o_data[2] = spo1; assign o_vld[2] = sv1;
  assign o_data[3] = dpo1; assign o_vld[3] = dv1;
  assign o_data[4] = spo2; assign o_vld[4] = sv2;
  assign o_data[5] = dpo2; assign o_vld[5] = dv2;
  assign o_data[6] = spo3; assign o_vld[6] = sv3;
  assign o_data[7] = dpo3; assign o_vld[7] = dv3;

  typedef struct {
    logic [15:0] data;
    logic        dc;
    int          cyc;
  } exp_t;

  exp_t        q [8][$];
  logic [15:0] last_exp [8];
  logic        last_dc  [8];
  logic [15:0] mem [128];
  logic        known [128];
  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  logic        mon_en = 1'b0;

  function automatic int wrm(input int inst);
    case (inst)
      1:       return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int org(input int inst);
    return (inst == 3) ? 1 : 0;
  endfunction

  task automatic ck(input bit ok, input string nm, input int ch,
                    input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s ch%0d actual=%0h required=%0h (t=%0t cyc=%0d)",
                  nm, ch, act, req, $time, cyc);
  endtask

  task automatic push(input int ch, input logic [15:0] d, input logic dc, input int due);
    exp_t e;
    e.data = d;
    e.dc   = dc;
    e.cyc  = due;
    q[ch].push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expectation whenever a valid is seen, checks the cycle it
  // was due on, and checks that data holds while valid is low.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mon_en) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (o_vld[ch] === 1'b1) begin
          ck(q[ch].size() != 0, "valid_expected", ch, 32'(o_vld[ch]), 32'd0);
          if (q[ch].size() != 0) begin
            e = q[ch].pop_front();
            ck(e.cyc == cyc, "latency", ch, 32'(cyc), 32'(e.cyc));
            if (!e.dc) ck(o_data[ch] === e.data, "data", ch, 32'(o_data[ch]), 32'(e.data));
            last_exp[ch] = e.data;
            last_dc[ch]  = e.dc;
          end
        end else begin
          ck(o_vld[ch] === 1'b0, "valid_known", ch, 32'(o_vld[ch]), 32'd0);
          if (q[ch].size() != 0 && q[ch][0].cyc <= cyc) begin
            ck(1'b0, "missing_valid", ch, 32'd0, 32'(q[ch][0].cyc));
            void'(q[ch].pop_front());
          end else if (!last_dc[ch]) begin
            ck(o_data[ch] === last_exp[ch], "hold", ch, 32'(o_data[ch]), 32'(last_exp[ch]));
          end
        end
      end
    end
  end

  // Drive one cycle of stimulus (called just after a falling edge) and push
  // the expected responses for every instance.
  task automatic issue(input logic ea, input logic wa, input logic [6:0] aa,
                       input logic [15:0] d, input logic eb, input logic [6:0] ba);
    int k;
    ena = ea; we = wa; a = aa; di = d; enb = eb; dpra = ba;
    k = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (ea) begin
        if (wa) begin
          if (wrm(i) == 0)      push(2*i, d, 1'b0, k + org(i));
          else if (wrm(i) == 1) push(2*i, mem[aa], !known[aa], k + org(i));
        end else begin
          push(2*i, mem[aa], !known[aa], k + org(i));
        end
      end
      if (eb) begin
        if (ea && wa && aa == ba) push(2*i+1, d, 1'b0, k + org(i));
        else                      push(2*i+1, mem[ba], !known[ba], k + org(i));
      end
    end
    if (ea && wa) begin
      mem[aa]   = d;
      known[aa] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    for (int ch = 0; ch < 8; ch++) begin
      ck(o_data[ch] === 16'h0, {nm, "_data"}, ch, 32'(o_data[ch]), 32'd0);
      ck(o_vld[ch] === 1'b0, {nm, "_valid"}, ch, 32'(o_vld[ch]), 32'd0);
    end
  endtask

  task automatic clear_scoreboard();
    for (int ch = 0; ch < 8; ch++) begin
      q[ch].delete();
      last_exp[ch] = 16'h0;
      last_dc[ch]  = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]   = 16'h0;
      known[i] = 1'b0;
    end
    clear_scoreboard();

    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("por");
    @(negedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    issue(1, 1, 7'd5, 16'h1111, 0, 7'd0);
    issue(1, 1, 7'd5, 16'h2222, 0, 7'd0);     // read-first sees 1111
    issue(0, 0, 7'd0, 16'h0,    1, 7'd5);     // port B sees 2222
    issue(1, 1, 7'd5, 16'hA5A5, 1, 7'd5);     // same-cycle collision
    issue(1, 1, 7'd3, 16'h3333, 0, 7'd0);
    issue(1, 1, 7'd0, 16'h0100, 0, 7'd0);
    issue(1, 1, 7'd1, 16'h0101, 0, 7'd0);
    issue(1, 1, 7'd2, 16'h0102, 0, 7'd0);
    issue(0, 0, 7'd0, 16'h0,    1, 7'd0);
    issue(0, 0, 7'd0, 16'h0,    1, 7'd1);
    issue(0, 0, 7'd0, 16'h0,    1, 7'd2);
    issue(0, 0, 7'd0, 16'h0,    0, 7'd0);
    issue(0, 0, 7'd0, 16'h0,    0, 7'd0);
    issue(0, 0, 7'd0, 16'h0,    0, 7'd0);
    issue(1, 1, 7'd127, 16'hBEEF, 1, 7'd127); // top address, collision
    issue(1, 0, 7'd127, 16'h0,  0, 7'd0);
    issue(1, 0, 7'd5,   16'h0,  1, 7'd3);
    issue(1, 1, 7'd10,  16'h1234, 1, 7'd127);
    issue(1, 0, 7'd10,  16'h0,  1, 7'd10);
    issue(0, 0, 7'd0,   16'h0,  0, 7'd0);
    issue(0, 0, 7'd0,   16'h0,  0, 7'd0);
    issue(0, 0, 7'd0,   16'h0,  0, 7'd0);

    // Reads in flight when reset hits mid-cycle are discarded.
    ena = 1'b1; we = 1'b0; a = 7'd127; enb = 1'b1; dpra = 7'd3;
    @(posedge clk);
    #2 rst = 1'b1;
    clear_scoreboard();
    #1 check_reset_outputs("async_rst");
    ena = 1'b1; we = 1'b1; a = 7'd3; di = 16'hDEAD; enb = 1'b0;  // ignored
    @(negedge clk);
    @(negedge clk);
    ena = 1'b0; we = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;

    issue(1, 0, 7'd3,   16'h0, 1, 7'd3);      // 3333 retained
    issue(1, 0, 7'd127, 16'h0, 1, 7'd0);
    issue(0, 0, 7'd0,   16'h0, 0, 7'd0);
    issue(0, 0, 7'd0,   16'h0, 0, 7'd0);
    issue(0, 0, 7'd0,   16'h0, 0, 7'd0);

    mon_en = 1'b0;
    for (int ch = 0; ch < 8; ch++) begin
      ck(q[ch].size() == 0, "drain", ch, 32'(q[ch].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
